// File: rtl/sha3_uart_host.sv
// sha3_uart_host: frames a message for the UART SHA3-256 bridge
// (SOF, len_h, len_l, payload) and collects the 32-byte digest reply.
// Ports: start/msg_len kick off a frame; msg_* is the payload stream;
// tx_* feeds uart_tx; rx_data/rx_ready/rx_ack talk to uart_rx;
// digest/done/err_timeout/busy/drop_cnt report status.
module sha3_uart_host #(
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  msg_len,
  input  logic [7:0]   msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready,
  output logic         rx_ack,
  output logic [255:0] digest,
  output logic         done,
  output logic         err_timeout,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, HDR_SOF, HDR_LEN_H, HDR_LEN_L,
    PAYLOAD, WAIT_DIG, FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [7:0]     hdr_q, hdr_d;
  logic [255:0]   digest_q, digest_d;
  logic [5:0]     dig_cnt_q, dig_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     drop_q, drop_d;
  logic           ack_blk_q;
  logic           ack;

  // ack_blk_q resets high so rx_ack stays low while in reset and
  // the cycle after; it also forbids back-to-back acks.
  assign ack      = rx_ready & ~ack_blk_q;
  assign rx_ack   = ack;
  assign busy     = (state_q != IDLE);
  assign digest   = digest_q;
  assign drop_cnt = drop_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_d       = hdr_q;
    digest_d    = digest_q;
    dig_cnt_d   = dig_cnt_q;
    tmo_d       = tmo_q;
    drop_d      = drop_q;
    tx_valid    = 1'b0;
    tx_data     = hdr_q;
    msg_ready   = 1'b0;
    done        = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = HDR_SOF;
          len_d     = msg_len;
          dig_cnt_d = '0;
          digest_d  = '0;
          tmo_d     = '0;
          hdr_d     = SOF_BYTE;
        end
      end
      HDR_SOF: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          state_d = HDR_LEN_H;
          hdr_d   = len_q[15:8];
        end
      end
      HDR_LEN_H: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          state_d = HDR_LEN_L;
          hdr_d   = len_q[7:0];
        end
      end
      HDR_LEN_L: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          hdr_d   = '0;
          tmo_d   = '0;
          state_d = (len_q == 16'd0) ? WAIT_DIG : PAYLOAD;
        end
      end
      PAYLOAD: begin
        tx_valid  = msg_valid;
        tx_data   = msg_data;
        msg_ready = tx_ready;
        if (msg_valid && tx_ready) begin
          len_d = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = WAIT_DIG;
            tmo_d   = '0;
          end
        end
      end
      WAIT_DIG: begin
        if (ack) begin
          digest_d  = {digest_q[247:0], rx_data};
          dig_cnt_d = dig_cnt_q + 6'd1;
          tmo_d     = '0;
          if (dig_cnt_q == 6'd31) state_d = FINISH;
        end else if (tmo_q == TMO_LAST) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ack && state_q != WAIT_DIG && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      hdr_q     <= '0;
      digest_q  <= '0;
      dig_cnt_q <= '0;
      tmo_q     <= '0;
      drop_q    <= '0;
      ack_blk_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_q     <= hdr_d;
      digest_q  <= digest_d;
      dig_cnt_q <= dig_cnt_d;
      tmo_q     <= tmo_d;
      drop_q    <= drop_d;
      ack_blk_q <= ack;
    end
  end

endmodule

// File: tb/tb_sha3_uart_host.sv
// tb_sha3_uart_host: scoreboard bench for sha3_uart_host.
// Expected tx bytes/digests queued at stimulus; negedge monitor checks.
module tb_sha3_uart_host;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  msg_len = '0;
  logic [7:0]   msg_data = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_ready = 1'b0;
  logic         rx_ack;
  logic [255:0] digest;
  logic         done;
  logic         err_timeout;
  logic         busy;
  logic [7:0]   drop_cnt;

  always #5 clk = ~clk;

  sha3_uart_host #(.TIMEOUT_CYCLES(TMO), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .digest(digest), .done(done), .err_timeout(err_timeout),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]   tx_exp[$];
  logic [255:0] dig_exp[$];
  logic [255:0] tmo_exp[$];
  logic [7:0]   src_q[$];
  logic [7:0]   rx_q[$];
  bit rnd_ready = 0;
  bit gapped = 0;
  bit src_took = 0;
  bit rx_took = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int mr_hi_cnt = 0;
  int last_ack_cyc = 0;
  int done_cyc = 0;
  int err_cyc = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  bit stall_p = 0;
  logic [7:0] stall_d = '0;
  bit ack_p = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 0;
      ack_p = 0;
    end else begin
      if (stall_p && tx_valid) check("tx_stable", tx_data, stall_d);
      stall_p = tx_valid && !tx_ready;
      stall_d = tx_data;
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (tx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got %0h required none", tx_data);
        end else begin
          check("tx_byte", tx_data, tx_exp.pop_front());
        end
      end
      if (msg_valid && msg_ready) src_took = 1;
      if (msg_ready) mr_hi_cnt++;
      if (rx_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        rx_took = 1;
        check("ack_gap", ack_p, 0);
      end
      ack_p = rx_ack;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (dig_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_extra: got done=1 required 0");
        end else begin
          check("digest", digest, dig_exp.pop_front());
        end
      end
      if (err_timeout) begin
        err_cnt++;
        err_cyc = cyc;
        if (tmo_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tmo_extra: got err_timeout=1 required 0");
        end else begin
          check("partial_digest", digest, tmo_exp.pop_front());
        end
      end
    end
  end

  // Payload source and tx_ready driver
  initial forever begin
    @(posedge clk); #1;
    if (src_took) begin
      src_took = 0;
      msg_valid = 1'b0;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (!msg_valid && src_q.size() > 0 &&
        (!gapped || $urandom_range(0, 2) != 0)) begin
      msg_data = src_q[0];
      msg_valid = 1'b1;
    end
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // uart_rx model: level rx_ready while a byte is held
  initial forever begin
    @(posedge clk); #1;
    if (rx_took) begin
      rx_took = 0;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    rx_ready = (rx_q.size() > 0);
    if (rx_q.size() > 0) rx_data = rx_q[0];
  end

  task automatic queue_frame(input logic [15:0] len,
                             input logic [7:0] pl[$]);
    tx_exp.push_back(8'hA5);
    tx_exp.push_back(len[15:8]);
    tx_exp.push_back(len[7:0]);
    foreach (pl[i]) begin
      tx_exp.push_back(pl[i]);
      src_q.push_back(pl[i]);
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_tx_drain(input string name);
    int n = 0;
    while (tx_exp.size() != 0 && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, tx_exp.size(), 0);
  endtask

  task automatic feed_digest(input logic [255:0] d);
    for (int i = 31; i >= 0; i--) rx_q.push_back(d[i*8 +: 8]);
    dig_exp.push_back(d);
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, done_cnt - d0, 1);
    check({name, "_lat"}, done_cyc - last_ack_cyc, 1);
    @(negedge clk); #1;
    check({name, "_pulse"}, done, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [255:0] exp;
    int x0;
    int a0;
    int n;
    int e0;
    int d0;
    int m0;

    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_msg_ready", msg_ready, 0);
    check("rst_rx_ack", rx_ack, 0);
    check("rst_digest", digest, 0);
    check("rst_done_err", {done, err_timeout}, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // bytes arriving while idle are dropped
    a0 = ack_cnt;
    for (int i = 0; i < 5; i++) rx_q.push_back(8'(8'h10 + i));
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (2) @(negedge clk);
    check("drop_acks", ack_cnt - a0, 5);
    check("drop_cnt", drop_cnt, 5);
    check("drop_busy", busy, 0);

    // "abc" with a second start issued while busy
    pl = '{8'h61, 8'h62, 8'h63};
    x0 = xfer_cnt;
    queue_frame(16'd3, pl);
    pulse_start(16'd3);
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_tx_valid", tx_valid, 1);
    check("start_sof", tx_data, 8'hA5);
    pulse_start(16'd9);
    wait_tx_drain("abc_tx");
    check("abc_xfers", xfer_cnt - x0, 6);
    feed_digest(256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532);
    wait_done("abc_done");
    repeat (5) @(negedge clk);
    check("abc_no_extra", xfer_cnt - x0, 6);
    check("abc_drop", drop_cnt, 5);

    // zero-length message
    pl.delete();
    x0 = xfer_cnt;
    m0 = mr_hi_cnt;
    queue_frame(16'd0, pl);
    pulse_start(16'd0);
    wait_tx_drain("len0_tx");
    check("len0_xfers", xfer_cnt - x0, 3);
    feed_digest(256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a);
    wait_done("len0_done");
    check("len0_msg_ready", mr_hi_cnt - m0, 0);

    // 300 bytes, random tx_ready, gapped source
    pl.delete();
    for (int i = 0; i < 300; i++) pl.push_back(8'(i * 7 + 3));
    x0 = xfer_cnt;
    rnd_ready = 1;
    gapped = 1;
    queue_frame(16'd300, pl);
    pulse_start(16'd300);
    wait_tx_drain("long_tx");
    rnd_ready = 0;
    gapped = 0;
    check("long_xfers", xfer_cnt - x0, 303);
    feed_digest(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    wait_done("long_done");

    // timeout after 10 digest bytes
    pl = '{8'h5A};
    queue_frame(16'd1, pl);
    pulse_start(16'd1);
    wait_tx_drain("tmo_tx");
    exp = '0;
    for (int i = 0; i < 10; i++) begin
      rx_q.push_back(8'(8'hB0 + i));
      exp = {exp[247:0], 8'(8'hB0 + i)};
    end
    tmo_exp.push_back(exp);
    e0 = err_cnt;
    d0 = done_cnt;
    n = 0;
    while (err_cnt == e0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("tmo_pulse", err_cnt - e0, 1);
    check("tmo_delay", err_cyc - last_ack_cyc, TMO);
    @(negedge clk); #1;
    check("tmo_single", err_timeout, 0);
    check("tmo_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("tmo_no_done", done_cnt - d0, 0);

    // reset during payload byte 2
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    x0 = xfer_cnt;
    queue_frame(16'd4, pl);
    pulse_start(16'd4);
    n = 0;
    while (xfer_cnt < x0 + 4 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_valid", tx_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_msg_ready", msg_ready, 0);
    check("rstmid_drop", drop_cnt, 0);
    tx_exp.delete();
    src_q.delete();
    msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pl = '{8'hC1, 8'hC2};
    x0 = xfer_cnt;
    queue_frame(16'd2, pl);
    pulse_start(16'd2);
    wait_tx_drain("post_rst_tx");
    check("post_rst_xfers", xfer_cnt - x0, 5);
    feed_digest(256'hfedcba9876543210fedcba9876543210fedcba9876543210fedcba9876543210);
    wait_done("post_rst_done");

    repeat (5) @(negedge clk);
    check("end_dig_q", dig_exp.size() + tmo_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
